tdm_demux16: RTL and testbench

- Receive-side counterpart to the 16:1 select path: takes one serial bit per valid beat in time-division slots and rebuilds a registered 16-bit parallel word.
- Slot 0 is marked by frame_sync. The internal slot counter plays the role of the select lines on the sending side.
- Sits downstream of any serialised lane link. Emits one dout_valid pulse per complete frame.

---
 rtl/tdm_demux16_if.sv | 25 ++
 rtl/tdm_demux16.sv | 128 ++++++++++++
 tb/tb_tdm_demux16.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux16_if.sv
// Serial TDM receive bus: one bit per qualified beat in, parallel frame and status out.
interface tdm_demux16_if #(
  parameter int LANES = 16,
  parameter int SEL_W = 4
) ();
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [LANES-1:0] dout;
  logic             dout_valid;
  logic [SEL_W-1:0] slot;
  logic             locked;
  logic             sync_err;
  logic             par_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err, par_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err, par_err
  );
endinterface

// File: rtl/tdm_demux16.sv
// TDM serial-to-parallel receiver: slot counter rebuilds a LANES-bit word per frame.
// Optional even-parity trailer beat enabled by defining TDM_PARITY_EN.
module tdm_demux16 #(
  parameter int LANES         = 16,
  parameter int SEL_W         = 4,
  parameter bit SYNC_REQUIRED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux16_if.slave bus
);

`ifdef TDM_PARITY_EN
  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {HUNT, DATA} state_t;
`endif

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES-1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [LANES-1:0] shadow_q, shadow_d;
  logic [LANES-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             se_q, se_d;
  logic             pe_q, pe_d;
  logic             lock_q, lock_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    lock_d   = lock_q;
    dv_d     = 1'b0;
    se_d     = 1'b0;
    pe_d     = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_d    = '0;
            shadow_d[0] = bus.din;
            slot_d      = SEL_W'(1);
            lock_d      = 1'b1;
            state_d     = DATA;
          end
        end
        DATA: begin
          if (bus.frame_sync) begin
            // sync away from slot 0 restarts the frame but keeps lock
            se_d        = (slot_q != '0);
            shadow_d    = '0;
            shadow_d[0] = bus.din;
            slot_d      = SEL_W'(1);
          end else if (slot_q == '0 && SYNC_REQUIRED) begin
            se_d    = 1'b1;
            lock_d  = 1'b0;
            state_d = HUNT;
          end else if (slot_q == LAST) begin
            slot_d = '0;
`ifdef TDM_PARITY_EN
            shadow_d[LAST] = bus.din;
            state_d        = PARITY;
`else
            dout_d = {bus.din, shadow_q[LANES-2:0]};
            dv_d   = 1'b1;
`endif
          end else begin
            shadow_d[slot_q] = bus.din;
            slot_d           = slot_q + 1'b1;
          end
        end
`ifdef TDM_PARITY_EN
        PARITY: begin
          state_d = DATA;
          if (bus.frame_sync) begin
            se_d        = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = bus.din;
            slot_d      = SEL_W'(1);
          end else begin
            slot_d = '0;
            if (^{shadow_q, bus.din} == 1'b0) begin
              dout_d = shadow_q;
              dv_d   = 1'b1;
            end else begin
              pe_d = 1'b1;
            end
          end
        end
`endif
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      se_q     <= 1'b0;
      pe_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      se_q     <= se_d;
      pe_q     <= pe_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = lock_q;
  assign bus.sync_err   = se_q;
  assign bus.par_err    = pe_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: strict-sync (u_a) and free-running (u_b) instances share stimulus.
module tb_tdm_demux16;
`ifdef TDM_PARITY_EN
  localparam int FL = 17;
`else
  localparam int FL = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din, dv, fs;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, va = 0, vb = 0, sea = 0, seb = 0, pea = 0, ta_last = 0, ta_prev = 0;
  int   a0, b0, s0, s1, p0;

  always #5 clk = ~clk;

  tdm_demux16_if ifa ();
  tdm_demux16_if ifb ();

  assign ifa.din = din;  assign ifa.din_valid = dv;  assign ifa.frame_sync = fs;
  assign ifb.din = din;  assign ifb.din_valid = dv;  assign ifb.frame_sync = fs;

  tdm_demux16 #(.LANES(16), .SEL_W(4), .SYNC_REQUIRED(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  tdm_demux16 #(.LANES(16), .SEL_W(4), .SYNC_REQUIRED(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ifa.dout_valid) begin
      va      <= va + 1;
      ta_prev <= ta_last;
      ta_last <= cyc;
    end
    if (ifb.dout_valid) vb  <= vb + 1;
    if (ifa.sync_err)   sea <= sea + 1;
    if (ifb.sync_err)   seb <= seb + 1;
    if (ifa.par_err)    pea <= pea + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic d);
    dv = v; fs = s; din = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic sync, input logic perr);
    for (int i = 0; i < 16; i++) beat(1'b1, sync && (i == 0), w[i]);
`ifdef TDM_PARITY_EN
    beat(1'b1, 1'b0, (^w) ^ perr);
`endif
  endtask

  initial begin
    logic [15:0] w;
    dv = 1'b0; fs = 1'b0; din = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",   ifa.dout,       0);
    chk("rst_dv",     ifa.dout_valid, 0);
    chk("rst_lock",   ifa.locked,     0);
    chk("rst_slot",   ifa.slot,       0);
    chk("rst_serr",   ifa.sync_err,   0);
    chk("rst_perr",   ifa.par_err,    0);
    rst = 1'b0;

    // synced frame A5C3, LSB in slot 0
    w = 16'hA5C3; a0 = va;
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, i == 0, w[i]);
      if (i == 14) chk("t1_novld", ifa.dout_valid, 0);
    end
`ifdef TDM_PARITY_EN
    chk("t1_novld_par", ifa.dout_valid, 0);
    beat(1'b1, 1'b0, ^w);
`endif
    chk("t1_vld",  ifa.dout_valid, 1);
    chk("t1_dout", ifa.dout,       32'hA5C3);
    chk("t1_lock", ifa.locked,     1);
    idle();
    chk("t1_vld_drop", ifa.dout_valid, 0);
    chk("t1_cnt",      va - a0,        1);

    // unsynced beats after reset are ignored
    rst = 1'b1; idle(); rst = 1'b0;
    s0 = sea;
    repeat (5) beat(1'b1, 1'b0, 1'b1);
    chk("t2_slot", ifa.slot,   0);
    chk("t2_lock", ifa.locked, 0);
    send_frame(16'h0001, 1'b1, 1'b0);
    chk("t2_dout", ifa.dout, 32'h0001);
    idle();
    chk("t2_serr", sea - s0, 0);

    // valid toggling every cycle, slot holds in gaps
    a0 = va;
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, i == 0, 1'b1);
      beat(1'b0, 1'b0, 1'b0);
      if (i == 3 || i == 9 || i == 15) chk("t3_slot_hold", ifa.slot, 32'((i + 1) % 16));
    end
`ifdef TDM_PARITY_EN
    beat(1'b1, 1'b0, 1'b0);
`endif
    idle();
    chk("t3_dout", ifa.dout, 32'hFFFF);
    chk("t3_cnt",  va - a0,  1);

    // early sync at slot 9 drops the partial frame
    a0 = va; s0 = sea;
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0, 1'(i));
    chk("t4_slot9", ifa.slot, 9);
    send_frame(16'h1234, 1'b1, 1'b0);
    idle();
    chk("t4_serr", sea - s0, 1);
    chk("t4_cnt",  va - a0,  1);
    chk("t4_dout", ifa.dout, 32'h1234);
    chk("t4_lock", ifa.locked, 1);

    // second frame without sync: strict drops lock, free-running accepts
    a0 = va; b0 = vb; s0 = sea; s1 = seb;
    send_frame(16'h5555, 1'b1, 1'b0);
    send_frame(16'h00FF, 1'b0, 1'b0);
    idle();
    chk("t5a_dout", ifa.dout,   32'h5555);
    chk("t5a_lock", ifa.locked, 0);
    chk("t5a_serr", sea - s0,   1);
    chk("t5a_cnt",  va - a0,    1);
    chk("t5b_dout", ifb.dout,   32'h00FF);
    chk("t5b_lock", ifb.locked, 1);
    chk("t5b_serr", seb - s1,   0);
    chk("t5b_cnt",  vb - b0,    2);

    // back-to-back frames: one pulse every frame length, no bubble
    send_frame(16'hBEEF, 1'b1, 1'b0);
    chk("t6_dout0", ifa.dout, 32'hBEEF);
    send_frame(16'h1357, 1'b1, 1'b0);
    chk("t6_dout1", ifa.dout, 32'h1357);
    idle();
    chk("t6_spacing", ta_last - ta_prev, FL);

`ifdef TDM_PARITY_EN
    a0 = va; p0 = pea;
    send_frame(16'h0003, 1'b1, 1'b0);
    idle();
    chk("tp_good_dout", ifa.dout, 32'h0003);
    chk("tp_good_cnt",  va - a0,  1);
    a0 = va;
    send_frame(16'h0007, 1'b1, 1'b1);
    idle();
    chk("tp_bad_dout", ifa.dout, 32'h0003);
    chk("tp_bad_perr", pea - p0, 1);
    chk("tp_bad_cnt",  va - a0,  0);
    chk("tp_bad_lock", ifa.locked, 1);
`endif

    // reset mid-frame
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b1);
    rst = 1'b1;
    beat(1'b1, 1'b0, 1'b1);
    chk("t7_dout", ifa.dout,       0);
    chk("t7_lock", ifa.locked,     0);
    chk("t7_slot", ifa.slot,       0);
    chk("t7_dv",   ifa.dout_valid, 0);
    chk("t7_serr", ifa.sync_err,   0);
    chk("t7_doutb", ifb.dout,      0);
    rst = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
